// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: hh:mm:ss timekeeper with hour/minute edit modes and a blink strobe.
// Optional build macro CLOCK_12H_EN selects a 12-hour clock (1..12 with pm flag);
// without it the clock runs 0..23 and pm stays 0.
module clock_time_ctrl #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_hours,
  input  logic       set_minutes,
  input  logic       inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       sec_tick,
  output logic       blink
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
`ifdef CLOCK_12H_EN
  localparam logic [4:0] HOURS_RST = 5'd12;
`else
  localparam logic [4:0] HOURS_RST = 5'd0;
`endif

  typedef enum logic [1:0] {RUN, SET_H, SET_M} mode_e;

  mode_e         mode_q, mode_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          inc_q;
  logic          inc_edge;
  logic          sec_tick_q, sec_tick_d;
  logic          blink_q, blink_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          pm_q, pm_d;
  logic [5:0]    hour_nxt;

  // Next hour value; the top bit flags that pm must toggle (11 -> 12 in 12h mode).
  function automatic logic [5:0] hour_step(input logic [4:0] h);
`ifdef CLOCK_12H_EN
    if (h == 5'd11)      return {1'b1, 5'd12};
    else if (h == 5'd12) return {1'b0, 5'd1};
    else                 return {1'b0, h + 5'd1};
`else
    if (h == 5'd23) return {1'b0, 5'd0};
    else            return {1'b0, h + 5'd1};
`endif
  endfunction

  assign hour_nxt = hour_step(hour_q);

  // Mode select, prescaler, time advance, edit increments and blink strobe.
  always_comb begin
    mode_d      = RUN;
    inc_edge    = inc & ~inc_q;
    presc_d     = presc_q;
    blink_cnt_d = (blink_cnt_q == CNT_MAX) ? '0 : blink_cnt_q + CW'(1);
    sec_tick_d  = 1'b0;
    blink_d     = 1'b0;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    pm_d        = pm_q;

    if (set_hours)        mode_d = SET_H;
    else if (set_minutes) mode_d = SET_M;

    unique case (mode_d)
      SET_H, SET_M: begin
        // Entering an edit from RUN discards the partial second; it stays frozen after.
        if (mode_q == RUN) begin
          presc_d = '0;
          sec_d   = '0;
        end
        blink_d = (blink_cnt_q >= CNT_HALF);
        if (inc_edge) begin
          if (mode_d == SET_H) begin
            hour_d = hour_nxt[4:0];
            pm_d   = pm_q ^ hour_nxt[5];
          end else begin
            min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          end
        end
      end
      default: begin
        if (presc_q == CNT_MAX) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = hour_nxt[4:0];
              pm_d   = pm_q ^ hour_nxt[5];
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + CW'(1);
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      inc_q       <= 1'b0;
      sec_tick_q  <= 1'b0;
      blink_q     <= 1'b0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= HOURS_RST;
      pm_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      inc_q       <= inc;
      sec_tick_q  <= sec_tick_d;
      blink_q     <= blink_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
    end
  end

  assign hours    = hour_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl with CLK_DIV=4; honours CLOCK_12H_EN like the design.
module tb_clock_time_ctrl;

  localparam int unsigned DIV = 4;
`ifdef CLOCK_12H_EN
  localparam int HRST = 12;
`else
  localparam int HRST = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       set_hours, set_minutes, inc;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       pm, sec_tick, blink;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic sh;
    logic sm;
    logic in;
    int   h;
    int   m;
    int   s;
  } vec_t;

  vec_t tbl[13];

  clock_time_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .set_hours(set_hours), .set_minutes(set_minutes),
    .inc(inc), .hours(hours), .minutes(minutes), .seconds(seconds),
    .pm(pm), .sec_tick(sec_tick), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hours"}, int'(hours), h);
    chk({name, "_minutes"}, int'(minutes), m);
    chk({name, "_seconds"}, int'(seconds), s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse();
    inc = 1'b1;
    step();
    inc = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; set_hours = 1'b0; set_minutes = 1'b0; inc = 1'b0;

    // Edit walk: {set_hours, set_minutes, inc, hours, minutes, seconds} after one edge.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 0, 2, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 0, 2, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 0, 2, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 0, 3, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 3, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1, 3, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1, 3, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1, 3, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1, 3, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1, 4, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1, 4, 0};

    @(posedge clk);
    #1;
    chk_time("reset", HRST, 0, 0);
    chk("reset_pm", int'(pm), 0);
    chk("reset_tick", int'(sec_tick), 0);
    chk("reset_blink", int'(blink), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

`ifdef CLOCK_12H_EN
    // 12h hour editing from 12 am through 11, 12 pm, then 1 pm.
    set_hours = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      pulse();
      chk($sformatf("h12_step%0d_hours", i), int'(hours), (i <= 12) ? i : 1);
      chk($sformatf("h12_step%0d_pm", i), int'(pm), (i >= 12) ? 1 : 0);
      chk($sformatf("h12_step%0d_sec", i), int'(seconds), 0);
    end
    set_hours = 1'b0;
`else
    // Free run from reset: a tick on every fourth edge, one minute after 240 edges.
    for (int i = 1; i <= 240; i++) begin
      step();
      chk($sformatf("run_tick%0d", i), int'(sec_tick), (i % 4 == 0) ? 1 : 0);
      chk($sformatf("run_blink%0d", i), int'(blink), 0);
    end
    chk_time("run240", 0, 1, 0);
    repeat (10) step();
    chk_time("run250", 0, 1, 2);

    // Table walk: mode priority, edge detect, RUN ignore, same-cycle mode+inc.
    for (int i = 0; i < 13; i++) begin
      set_hours = tbl[i].sh;
      set_minutes = tbl[i].sm;
      inc = tbl[i].in;
      step();
      chk_time($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s);
      chk($sformatf("vec%0d_tick", i), int'(sec_tick), 0);
      chk($sformatf("vec%0d_blink", i), int'(blink),
          ((tbl[i].sh | tbl[i].sm) && (((cyc - 1) % 4) >= 2)) ? 1 : 0);
    end
    inc = 1'b0;

    // Held inc in SET_H increments hours exactly once; seconds stay frozen.
    set_hours = 1'b1;
    inc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("hold%0d_hours", i), int'(hours), 2);
      chk($sformatf("hold%0d_sec", i), int'(seconds), 0);
      chk($sformatf("hold%0d_tick", i), int'(sec_tick), 0);
    end
    inc = 1'b0;
    set_hours = 1'b0;
    set_minutes = 1'b1;
    step();

    // Minutes wrap 59 -> 0 without touching hours.
    repeat (56) pulse();
    chk_time("min_zero", 2, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      pulse();
      chk($sformatf("min_pulse%0d", i), int'(minutes), i % 60);
    end
    chk("min_wrap_hours", int'(hours), 2);

    // Preload 23:59 (through an hour wrap 23 -> 0), then run into midnight.
    set_minutes = 1'b0;
    set_hours = 1'b1;
    repeat (21) pulse();
    chk("pre_h23", int'(hours), 23);
    pulse();
    chk_time("hour_wrap", 0, 0, 0);
    repeat (23) pulse();
    set_hours = 1'b0;
    set_minutes = 1'b1;
    repeat (59) pulse();
    chk_time("preload", 23, 59, 0);
    set_minutes = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (i == 236) chk_time("mid_236", 23, 59, 59);
    end
    chk_time("midnight", 0, 0, 0);
    chk("midnight_tick", int'(sec_tick), 1);

    // Reach 05:17:33 in RUN, then pulse reset and look before the next edge.
    set_hours = 1'b1;
    repeat (5) pulse();
    set_hours = 1'b0;
    set_minutes = 1'b1;
    repeat (17) pulse();
    set_minutes = 1'b0;
    repeat (132) step();
    chk_time("pre_rst", 5, 17, 33);
    rst = 1'b1;
    #2;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst_tick", int'(sec_tick), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("post_rst_tick%0d", i), int'(sec_tick), (i == 4) ? 1 : 0);
    end
    chk_time("post_rst", 0, 0, 1);
    chk("post_rst_pm", int'(pm), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
